// File: rtl/exec_unit_mc.sv
`default_nettype none
// exec_unit_mc: handshaked execute stage with a registered result, {V,N,Z,C} flags and port data.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier (MUL/MULI) and its stall.
module exec_unit_mc #(
   parameter int WIDTH = 16,
   parameter int OPW   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op_dec,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] ans_ex,
   output logic [WIDTH-1:0] DM_data,
   output logic [WIDTH-1:0] data_out,
   output logic [3:0]       flag_ex
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [OPW-1:0] OP_ADD = OPW'(6'b000000), OP_SUB = OPW'(6'b000001);
   localparam logic [OPW-1:0] OP_MOV = OPW'(6'b000010), OP_AND = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_OR  = OPW'(6'b000101), OP_XOR = OPW'(6'b000110);
   localparam logic [OPW-1:0] OP_NOT = OPW'(6'b000111), OP_ADI = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_SBI = OPW'(6'b001001), OP_MVI = OPW'(6'b001010);
   localparam logic [OPW-1:0] OP_ANI = OPW'(6'b001100), OP_ORI = OPW'(6'b001101);
   localparam logic [OPW-1:0] OP_XRI = OPW'(6'b001110), OP_NTI = OPW'(6'b001111);
   localparam logic [OPW-1:0] OP_RET = OPW'(6'b010000), OP_HLT = OPW'(6'b010001);
   localparam logic [OPW-1:0] OP_LD  = OPW'(6'b010100), OP_ST  = OPW'(6'b010101);
   localparam logic [OPW-1:0] OP_IN  = OPW'(6'b010110), OP_OUT = OPW'(6'b010111);
   localparam logic [OPW-1:0] OP_JMP = OPW'(6'b011000), OP_LS  = OPW'(6'b011001);
   localparam logic [OPW-1:0] OP_RS  = OPW'(6'b011010), OP_RSA = OPW'(6'b011011);
   localparam logic [OPW-1:0] OP_JV  = OPW'(6'b011100), OP_JNV = OPW'(6'b011101);
   localparam logic [OPW-1:0] OP_JZ  = OPW'(6'b011110), OP_JNZ = OPW'(6'b011111);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] ans_q, ans_d, dm_q, dm_d, dout_q, dout_d;
   logic [3:0]       flag_q, flag_d;

   logic             w_accept, w_mul_start, w_big, w_v, w_c, w_upd_ans, w_upd_flags;
   logic [WIDTH-1:0] w_opb, w_ans;
   logic [WIDTH:0]   w_sum;
   logic [SHW-1:0]   w_shamt;

`ifdef EXEC_MUL_EN
   localparam logic [OPW-1:0] OP_MUL = OPW'(6'b000011), OP_MULI = OPW'(6'b001011);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, w_acc_nxt;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   assign in_ready    = (state_q == ST_IDLE);
   assign w_mul_start = (op_dec == OP_MUL) || (op_dec == OP_MULI);
`else
   assign in_ready    = 1'b1;
   assign w_mul_start = 1'b0;
`endif

   assign w_accept = in_valid & in_ready;
   // Immediate forms (001xxx) take data_in in place of B.
   assign w_opb    = op_dec[3] ? data_in : B;
   assign w_shamt  = B[SHW-1:0];
   assign w_big    = |(B >> SHW);

   always_comb begin
      w_sum       = '0;
      w_ans       = '0;
      w_v         = 1'b0;
      w_c         = 1'b0;
      w_upd_ans   = 1'b1;
      w_upd_flags = 1'b1;
      case (op_dec)
         OP_ADD, OP_ADI: begin
            w_sum = {1'b0, A} + {1'b0, w_opb};
            w_ans = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (A[MSB] == w_opb[MSB]) && (w_ans[MSB] != A[MSB]);
         end
         OP_SUB, OP_SBI: begin
            w_sum = {1'b0, A} + {1'b0, ~w_opb} + {{WIDTH{1'b0}}, 1'b1};
            w_ans = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (A[MSB] != w_opb[MSB]) && (w_ans[MSB] != A[MSB]);
         end
         OP_MOV, OP_MVI:         w_ans = w_opb;
         OP_AND, OP_ANI:         w_ans = A & w_opb;
         OP_OR,  OP_ORI:         w_ans = A | w_opb;
         OP_XOR, OP_XRI:         w_ans = A ^ w_opb;
         OP_NOT, OP_NTI:         w_ans = ~w_opb;
         OP_LD, OP_ST, OP_OUT:   w_ans = A;
         OP_IN:                  w_ans = data_in;
         OP_LS:  w_ans = w_big ? '0 : (A << w_shamt);
         OP_RS:  w_ans = w_big ? '0 : (A >> w_shamt);
         OP_RSA: w_ans = w_big ? {WIDTH{A[MSB]}} : WIDTH'($signed(A) >>> w_shamt);
         OP_RET, OP_HLT, OP_JMP, OP_JV, OP_JNV, OP_JZ, OP_JNZ: begin
            w_upd_ans   = 1'b0;
            w_upd_flags = 1'b0;
         end
         default: w_upd_flags = 1'b0;
      endcase
   end

   always_comb begin
      out_valid_d = 1'b0;
      ans_d       = ans_q;
      flag_d      = flag_q;
      dm_d        = dm_q;
      dout_d      = dout_q;
      if (w_accept) begin
         dm_d = B;
         if (!w_mul_start) begin
            out_valid_d = 1'b1;
            dout_d      = (op_dec == OP_OUT) ? A : '0;
            if (w_upd_ans)   ans_d  = w_ans;
            if (w_upd_flags) flag_d = {w_v, w_ans[MSB], ~|w_ans, w_c};
         end
      end
`ifdef EXEC_MUL_EN
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      w_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      if (state_q == ST_IDLE) begin
         if (w_accept && w_mul_start) begin
            state_d  = ST_MUL;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = w_opb;
            acc_d    = '0;
         end
      end else begin
         acc_d    = w_acc_nxt;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + SHW'(1);
         // Result is taken from the final partial sum, so out_valid follows the last iteration.
         if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            dout_d      = '0;
            ans_d       = w_acc_nxt[MSB:0];
            flag_d      = {|w_acc_nxt[2*WIDTH-1:WIDTH], w_acc_nxt[MSB], ~|w_acc_nxt[MSB:0],
                           |w_acc_nxt[2*WIDTH-1:WIDTH]};
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         ans_q       <= '0;
         flag_q      <= '0;
         dm_q        <= '0;
         dout_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         ans_q       <= ans_d;
         flag_q      <= flag_d;
         dm_q        <= dm_d;
         dout_q      <= dout_d;
      end
   end

`ifdef EXEC_MUL_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign ans_ex    = ans_q;
   assign flag_ex   = flag_q;
   assign DM_data   = dm_q;
   assign data_out  = dout_q;
endmodule
`default_nettype wire
